// File: rtl/alu_uart_tx.sv
// alu_uart_tx: transmit side of the ALU 8N1 serial link.
// Bytes arrive on a valid/ready stream, wait in a small circular FIFO and are
// shifted out LSB-first on tx_o, one bit every ClksPerBit clocks.
// Optional feature macro: ALU_UART_TX_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit (8E1 instead of 8N1).
module alu_uart_tx #(
  parameter int ClkFreqHz = 12000000,
  parameter int BaudRate  = 115200,
  parameter int FifoDepth = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int ClksPerBit = ClkFreqHz / BaudRate;
  localparam int BaudW      = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int PtrW       = $clog2(FifoDepth);
  localparam int CntW       = PtrW + 1;

`ifdef ALU_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state;
  logic [BaudW-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;

  logic [7:0]       mem [FifoDepth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;
  logic [CntW-1:0]  count_next;

  logic push;
  logic pop;
  logic last_tick;
  logic stop_done;
  logic idle_next;

  // Full is judged from the registered count only, so a same-cycle pop never
  // reopens the input while the FIFO is full.
  assign ready_o   = (count != CntW'(FifoDepth));
  assign push      = valid_i && ready_o;
  assign last_tick = (baud_cnt == BaudW'(ClksPerBit - 1));
  assign stop_done = (state == STOP) && last_tick;
  // The head is popped either from idle or on the last stop clock, which lets
  // back-to-back frames run without an idle gap.
  assign pop       = (count != '0) && ((state == IDLE) || stop_done);
  assign idle_next = ((state == IDLE) || stop_done) && !pop;

  // Occupancy after this edge, used for the count register and busy_o.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CntW'(1);
    end else if (!push && pop) begin
      count_next = count - CntW'(1);
    end
  end

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FifoDepth.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      count <= count_next;
    end
  end

`ifdef ALU_UART_TX_PARITY_EN
  logic parity;

  // Even parity of the byte, captured when it leaves the FIFO.
  always_ff @(posedge clk_i) begin
    if (pop) begin
      parity <= ^mem[rd_ptr];
    end
  end
`endif

  // Shift register: loaded on pop, shifted right at the end of each data bit.
  always_ff @(posedge clk_i) begin
    if (pop) begin
      shift <= mem[rd_ptr];
    end else if ((state == DATA) && last_tick) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx_o     <= 1'b1;
      busy_o   <= 1'b0;
    end else begin
      busy_o <= !idle_next || (count_next != '0);

      case (state)
        START:   tx_o <= 1'b0;
        DATA:    tx_o <= shift[0];
`ifdef ALU_UART_TX_PARITY_EN
        PARITY:  tx_o <= parity;
`endif
        default: tx_o <= 1'b1;
      endcase

      if (pop) begin
        state    <= START;
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (state != IDLE) begin
        if (!last_tick) begin
          baud_cnt <= baud_cnt + BaudW'(1);
        end else begin
          baud_cnt <= '0;
          case (state)
            START: state <= DATA;
            DATA: begin
              if (bit_cnt == 3'd7) begin
`ifdef ALU_UART_TX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
`ifdef ALU_UART_TX_PARITY_EN
            PARITY: state <= STOP;
`endif
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
